// File: rtl/cpu_run_ctrl_if.sv
// Host command channel for the CPU run/debug sequencer.
// The host drives a command strobe; the sequencer answers with ready.
interface cpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer: produces the CPU-wide enable from host
// commands, a single PC breakpoint and a step counter.
module cpu_run_ctrl #(
  parameter int unsigned PC_W     = 64,
  parameter int unsigned CNT_W    = 32,
  parameter bit          AUTO_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  cpu_run_ctrl_if.slave    cmd,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       run_state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_e;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_HOST = 2'b01;
  localparam logic [1:0] C_BP   = 2'b10;
  localparam logic [1:0] C_STEP = 2'b11;

  localparam state_e S_RST = AUTO_RUN ? S_RUN : S_HALT;

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             skip_q, skip_d;

  logic running, is_halt, bp_hit, accept;

  // Enable, handshake and next-state decode.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    rem_d   = rem_q;
    ret_d   = ret_q;

    running = (state_q != S_HALT);
    is_halt = cmd.cmd_valid && (cmd.cmd_op == OP_HALT);
    bp_hit  = bp_en && (pc == bp_addr) && !skip_q;
    cpu_en  = running && !bp_hit && !is_halt;

    cmd.cmd_ready = !running
                 || (cmd.cmd_op == OP_HALT)
                 || (cmd.cmd_op == OP_CLR);
    accept = cmd.cmd_valid && cmd.cmd_ready;

    // The breakpoint is skipped until one instruction commits.
    skip_d = cpu_en ? 1'b0 : skip_q;

    unique case (state_q)
      S_HALT: begin
        if (accept) begin
          unique case (cmd.cmd_op)
            OP_HALT: cause_d = C_HOST;
            OP_RUN: begin
              state_d = S_RUN;
              cause_d = C_NONE;
              skip_d  = 1'b1;
            end
            OP_STEP: begin
              state_d = S_STEP;
              cause_d = C_NONE;
              skip_d  = 1'b1;
              rem_d   = (cmd.cmd_arg == '0)
                      ? CNT_W'(1) : cmd.cmd_arg;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (is_halt) begin
          state_d = S_HALT;
          cause_d = C_HOST;
        end else if (bp_hit) begin
          state_d = S_HALT;
          cause_d = C_BP;
        end
      end
      S_STEP: begin
        if (cpu_en) rem_d = rem_q - CNT_W'(1);
        if (is_halt) begin
          state_d = S_HALT;
          cause_d = C_HOST;
        end else if (bp_hit) begin
          state_d = S_HALT;
          cause_d = C_BP;
        end else if (rem_q == CNT_W'(1)) begin
          state_d = S_HALT;
          cause_d = C_STEP;
        end
      end
      default: state_d = S_HALT;
    endcase

    if (accept && (cmd.cmd_op == OP_CLR))
      ret_d = '0;
    else if (cpu_en && (ret_q != '1))
      ret_d = ret_q + CNT_W'(1);

    halted     = (state_q == S_HALT);
    run_state  = state_q;
    halt_cause = cause_q;
    retired    = ret_q;
  end

  // Sequencer state, counters and breakpoint skip flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      cause_q <= C_NONE;
      ret_q   <= '0;
      rem_q   <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/debug sequencer for the single-cycle 64-bit CPU. It produces the CPU-wide enable `cpu_en`, which gates PC update, register-file write and data-memory write. It is driven by a host command interface (halt, run, step N, clear count) and a single PC breakpoint. It sits between the testbench/host and the top-level CPU, observing the fetch PC and counting retired instructions.

Parameters:
PC_W, 64, width of fetch PC and breakpoint address
CNT_W, 32, width of step argument and retired-instruction counter
AUTO_RUN, 1, 1: leave reset in RUN; 0: leave reset in HALTED

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  host command strobe, one command per asserted cycle
cmd_op  input  2  00 HALT, 01 RUN, 10 STEP, 11 CLEAR_COUNT
cmd_arg  input  CNT_W  STEP instruction count (0 treated as 1)
cmd_ready  output  1  command accepted this cycle
bp_en  input  1  breakpoint enable
bp_addr  input  PC_W  breakpoint PC
pc  input  PC_W  current fetch PC from the instruction fetch unit
cpu_en  output  1  CPU executes/commits the instruction at `pc` this cycle
halted  output  1  state == HALTED
run_state  output  2  00 HALTED, 01 RUN, 10 STEP
halt_cause  output  2  00 none, 01 host, 10 breakpoint, 11 step done
retired  output  CNT_W  count of cycles with cpu_en=1, saturating

Behaviour:
- Reset (async, immediate):
  - state = RUN if AUTO_RUN else HALTED
  - halt_cause=00, retired=0, remaining=0, skip_bp=0
  - outputs follow the state combinationally
- Breakpoint hit: `bp_hit = bp_en && pc==bp_addr && !skip_bp`.
- `cpu_en` (combinational) = (state==RUN || state==STEP) && !bp_hit && !(cmd_valid && cmd_op==HALT). A halt command or breakpoint suppresses execution in the same cycle.
- cmd_ready:
  - HALTED: always 1.
  - RUN/STEP: 1 only for HALT and CLEAR_COUNT.
  - RUN/STEP commands issued while running are not accepted and have no effect.
- HALTED:
  - RUN accepted → RUN next cycle.
  - STEP accepted → STEP next cycle, remaining = max(cmd_arg,1).
  - Both set skip_bp=1 and halt_cause=00.
  - HALT while HALTED sets halt_cause=01.
- skip_bp:
  - Cleared after the first cycle with cpu_en=1, so resuming from a breakpoint PC executes that instruction once.
  - Held while cpu_en=0.
- RUN:
  - bp_hit → HALTED, cause 10.
  - Accepted HALT → HALTED, cause 01.
  - Otherwise stay.
- STEP:
  - Each cpu_en cycle decrements remaining.
  - If remaining==1 and cpu_en → HALTED, cause 11.
  - bp_hit → HALTED, cause 10; remaining is left as-is.
  - HALT → HALTED, cause 01.
- Priority when several events coincide in one cycle: HALT cmd > bp_hit > step completion.
- retired:
  - +1 on each cpu_en cycle; saturates at 2^CNT_W−1.
  - CLEAR_COUNT (accepted in any state) sets retired=0 next cycle. Clear wins over a same-cycle increment.
- Latency:
  - State change is visible one cycle after the triggering edge.
  - cpu_en responds to pc/bp/HALT combinationally (zero latency).
- Reset asserted mid-RUN/STEP aborts immediately; remaining is discarded.

Test Plan:
1. Reset with AUTO_RUN=1, no commands, 10 clocks → cpu_en=1 every cycle, retired=10, run_state=01, halt_cause=00.
2. AUTO_RUN=0, reset, then STEP arg=3 → exactly 3 cycles of cpu_en=1, then halted=1, halt_cause=11, retired=3. Repeat with STEP arg=0 → exactly 1 cycle of cpu_en=1.
3. bp_en=1, bp_addr=0x18, RUN with pc sequence 0x0,0x4,…:
   - cpu_en=0 in the cycle pc=0x18.
   - halted next cycle, cause 10, retired=6.
   - RUN again → instruction at 0x18 executes (cpu_en=1), then execution continues.
4. In RUN, assert HALT → cpu_en=0 that same cycle, halted next cycle, cause 01. RUN/STEP issued mid-RUN → cmd_ready=0, state unchanged.
5. CLEAR_COUNT in the same cycle as a cpu_en=1 increment → retired=0 next cycle. Preload retired to 0xFFFFFFFF → stays 0xFFFFFFFF after further execution.
6. Assert reset during STEP with remaining=5 → immediate return to reset state, retired=0, halt_cause=00.
